gfx_lane_writer: RTL

- Sink for the shader processor's outbound lane stream (send_valid/send_ready/send_data/send_mask).
- Accepts a programmed number of lane beats and writes each enabled lane back to VRAM as consecutive word writes over an Avalon-MM write master.
- It is the write-side counterpart of the SP batch reader: results land at a strided VRAM region set at start time.

---
 rtl/gfx_lane_writer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/gfx_lane_writer.sv
// Drains the shader lane stream into VRAM: each accepted beat is written out lane by lane,
// one word per Avalon write, into a strided region that advances by one beat per beat.
module gfx_lane_writer #(
    parameter int LANES  = 4,
    parameter int LANE_W = 32,
    parameter int WORD_W = 16,
    parameter int ADDR_W = 25,
    parameter int CNT_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [CNT_W-1:0]        beat_count,
    output logic                    busy,
    output logic                    done,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*LANE_W-1:0] in_data,
    input  logic [LANES-1:0]        in_mask,
    output logic [ADDR_W-1:0]       vram_address,
    output logic                    vram_write,
    output logic [WORD_W-1:0]       vram_writedata,
    input  logic                    vram_waitrequest
);
    localparam int WPL    = LANE_W / WORD_W;
    localparam int STRIDE = LANES * WPL;
    localparam int SLOTS  = LANES * WPL;
    localparam int LN_W   = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int WD_W   = (WPL > 1) ? $clog2(WPL) : 1;
    localparam int SL_W   = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, FINISH} state_t;

    state_t                    state_q;
    logic [ADDR_W-1:0]         beat_addr_q;
    logic [CNT_W-1:0]          beats_left_q;
    logic [LANES*LANE_W-1:0]   data_q;
    logic [LANES-1:0]          mask_q;
    logic [LN_W-1:0]           lane_q;
    logic [WD_W-1:0]           word_q;
    logic                      busy_q, done_q, in_ready_q, vram_write_q;
    logic [ADDR_W-1:0]         vram_address_q;
    logic [WORD_W-1:0]         vram_writedata_q;

    logic                      lane_done, last_slot, advance;
    logic [LN_W-1:0]           lane_d;
    logic [WD_W-1:0]           word_d;
    logic [LN_W-1:0]           sl_lane;
    logic [WD_W-1:0]           sl_word;
    logic [LANES*LANE_W-1:0]   sl_data;
    logic [LANES-1:0]          sl_mask;
    logic [SLOTS-1:0][WORD_W-1:0] sl_words;
    logic [SL_W-1:0]           sl_idx;
    logic                      slot_wr;
    logic [ADDR_W-1:0]         slot_addr;
    logic [WORD_W-1:0]         slot_dat;

    // A masked lane is consumed in a single idle cycle regardless of WPL.
    always_comb begin
        lane_done = !mask_q[lane_q] || (word_q == WD_W'(WPL - 1));
        last_slot = lane_done && (lane_q == LN_W'(LANES - 1));
        lane_d    = lane_done ? lane_q + 1'b1 : lane_q;
        word_d    = lane_done ? '0 : word_q + 1'b1;
        advance   = vram_write_q ? !vram_waitrequest : 1'b1;
    end

    // Outputs of the slot about to be presented: slot 0 of the incoming beat on a
    // handshake, otherwise the next slot of the latched beat.
    always_comb begin
        if (state_q == ACCEPT) begin
            sl_lane = '0;
            sl_word = '0;
            sl_data = in_data;
            sl_mask = in_mask;
        end else begin
            sl_lane = lane_d;
            sl_word = word_d;
            sl_data = data_q;
            sl_mask = mask_q;
        end
        sl_words  = sl_data;
        sl_idx    = SL_W'(sl_lane) * SL_W'(WPL) + SL_W'(sl_word);
        slot_wr   = sl_mask[sl_lane];
        slot_addr = beat_addr_q + ADDR_W'(sl_lane) * ADDR_W'(WPL) + ADDR_W'(sl_word);
        slot_dat  = sl_words[sl_idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            beat_addr_q      <= '0;
            beats_left_q     <= '0;
            data_q           <= '0;
            mask_q           <= '0;
            lane_q           <= '0;
            word_q           <= '0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            in_ready_q       <= 1'b0;
            vram_write_q     <= 1'b0;
            vram_address_q   <= '0;
            vram_writedata_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    beat_addr_q  <= base_addr;
                    beats_left_q <= beat_count;
                    busy_q       <= 1'b1;
                    if (beat_count == '0) begin
                        state_q <= FINISH;
                    end else begin
                        state_q    <= ACCEPT;
                        in_ready_q <= 1'b1;
                    end
                end
                ACCEPT: if (in_valid && in_ready_q) begin
                    data_q           <= in_data;
                    mask_q           <= in_mask;
                    lane_q           <= '0;
                    word_q           <= '0;
                    in_ready_q       <= 1'b0;
                    state_q          <= WRITE;
                    vram_write_q     <= slot_wr;
                    vram_address_q   <= slot_addr;
                    vram_writedata_q <= slot_dat;
                end
                WRITE: if (advance) begin
                    if (last_slot) begin
                        beat_addr_q  <= beat_addr_q + ADDR_W'(STRIDE);
                        beats_left_q <= beats_left_q - 1'b1;
                        vram_write_q <= 1'b0;
                        if (beats_left_q == CNT_W'(1)) begin
                            state_q <= FINISH;
                        end else begin
                            state_q    <= ACCEPT;
                            in_ready_q <= 1'b1;
                        end
                    end else begin
                        lane_q           <= lane_d;
                        word_q           <= word_d;
                        vram_write_q     <= slot_wr;
                        vram_address_q   <= slot_addr;
                        vram_writedata_q <= slot_dat;
                    end
                end
                FINISH: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign in_ready       = in_ready_q;
    assign vram_write     = vram_write_q;
    assign vram_address   = vram_address_q;
    assign vram_writedata = vram_writedata_q;
endmodule
